// File: rtl/mem_stage_responder.sv
// Multi-cycle data-memory responder for the MEM stage load/store port.
// Holds ready low while an access is in flight so the pipeline freezes,
// then returns load data through a registered output.
//
// Handshake: the initiator raises MEM_R_EN and/or MEM_W_EN and holds them
// stable with address/dataIn until it sees ready=1. ready=1 in IDLE with
// no request means "nothing pending". ready=1 in DONE means "this request
// completes on this edge". The request is captured once, in IDLE. Inputs
// are ignored during ACCESS and DONE.
module mem_stage_responder #(
  parameter int WORD_LEN  = 32,
  parameter int DEPTH     = 64,
  parameter int ADDR_BASE = 1024,
  parameter int LATENCY   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                MEM_R_EN,
  input  logic                MEM_W_EN,
  input  logic [WORD_LEN-1:0] address,
  input  logic [WORD_LEN-1:0] dataIn,
  output logic [WORD_LEN-1:0] dataOut,
  output logic                ready,
  output logic                addr_err,
  output logic [1:0]          state_dbg
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_LEN-1:0] addr_q, addr_d;
  logic [WORD_LEN-1:0] data_q, data_d;
  logic                wr_q, wr_d;
  logic [WORD_LEN-1:0] dout_q, dout_d;
  logic                err_q, err_d;
  logic [WORD_LEN-1:0] mem_q [DEPTH];
  logic [WORD_LEN-1:0] mem_d [DEPTH];

  logic                req;
  logic [WORD_LEN-1:0] idx_full;
  logic [IDX_W-1:0]    idx;
  logic                acc_err;

  // Decode the latched byte address into a word index and an error flag.
  // The subtraction wraps for addresses below the base. That case is flagged
  // separately, so the wrapped index is never used.
  always_comb begin
    req      = MEM_R_EN | MEM_W_EN;
    idx_full = (addr_q - WORD_LEN'(ADDR_BASE)) >> 2;
    idx      = idx_full[IDX_W-1:0];
    acc_err  = (addr_q[1:0] != 2'b00) ||
               (addr_q < WORD_LEN'(ADDR_BASE)) ||
               (idx_full >= WORD_LEN'(DEPTH));
  end

  // Next-state, datapath and ready logic for the IDLE/ACCESS/DONE sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = wr_q;
    dout_d  = dout_q;
    err_d   = 1'b0;
    mem_d   = mem_q;
    ready   = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = ~req;
        if (req) begin
          addr_d  = address;
          data_d  = dataIn;
          wr_d    = MEM_W_EN;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = S_DONE;
          err_d   = acc_err;
          if (wr_q) begin
            if (!acc_err) mem_d[idx] = data_q;
          end else begin
            dout_d = acc_err ? '0 : mem_q[idx];
          end
        end
      end
      S_DONE: begin
        ready   = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, latched request and storage registers. Reset clears everything
  // and aborts any in-flight access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      dout_q  <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
      mem_q   <= mem_d;
    end
  end

  assign dataOut   = dout_q;
  assign addr_err  = err_q;
  assign state_dbg = state_q;

endmodule
